horner_pipe: RTL and testbench
==============================

Name: horner_pipe

Overview:
- Parametrised, fully pipelined fixed-point polynomial evaluator: y = c0 + c1·x + … + c(N-1)·x^(N-1), evaluated by Horner's rule.
- One registered multiply-add stage per Horner step.
- Runtime-writable coefficient bank; resets to the e^x Taylor series.
- Sits in the datapath between a valid/ready producer and consumer, with correct backpressure: a stalled output is held, never overwritten.

Parameters:
- WIDTHIN, 16, width of i_x and of each coefficient (unsigned fixed point, FRAC_IN fraction bits).
- FRAC_IN, 14, fraction bits of i_x and coefficients (Q2.14 by default).
- WIDTHOUT, 32, width of accumulator and o_y.
- FRAC_OUT, 25, fraction bits of accumulator/o_y (Q7.25 by default). Must satisfy FRAC_OUT ≥ FRAC_IN.
- NTERMS, 6, number of coefficients. Range 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_valid  in  1  upstream sample valid
- o_ready  out  1  block can accept a sample this cycle
- i_x  in  WIDTHIN  input sample
- o_valid  out  1  o_y holds a valid result
- i_ready  in  1  downstream accepts o_y this cycle
- o_y  out  WIDTHOUT  result
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  $clog2(NTERMS)  coefficient index k (for c_k)
- i_coef_wdata  in  WIDTHIN  coefficient value
- o_coef_err  out  1  one-cycle pulse: write dropped
- o_busy  out  1  any pipeline stage holds a valid sample

Behaviour:
- Clock/reset: clock clk; reset `reset`, asynchronous, active-high.
- Reset values:
  - All valid bits, o_valid, o_coef_err and o_busy are 0.
  - o_y is 0.
  - coef[k] = EXP_COEF[k]: 0x4000, 0x4000, 0x2000, 0x0AAA, 0x02AA, 0x0088; 0 for k ≥ 6.
- Pipeline structure:
  - Input register (x, valid), followed by NTERMS-1 MAC stages.
  - Each stage carries its own delayed copy of x.
  - The last stage register drives o_y/o_valid directly.
- Global advance: adv = ~o_valid | i_ready.
  - o_ready = adv.
  - All stage registers (data and valid) update only when adv = 1.
  - When adv = 0, every stage holds, and o_y/o_valid remain stable.
- Accept: a sample is taken when i_valid & o_ready. When adv = 1 and i_valid = 0, a bubble (valid = 0) enters.
- Latency: a sample accepted at the end of cycle 0 appears with o_valid = 1 in cycle NTERMS, provided there are no stalls. Throughput is 1 sample/cycle.
- Arithmetic (unsigned, modulo 2^WIDTHOUT):
  - Coefficient alignment: align(c) = c << (FRAC_OUT-FRAC_IN), zero-extended to WIDTHOUT.
  - Stage 1: acc = (align(c[N-1]) * x) >> FRAC_IN, truncated to WIDTHOUT, + align(c[N-2]).
  - Stage j (j ≥ 2): acc = ((acc_prev * x_j) >> FRAC_IN)[WIDTHOUT-1:0] + align(c[N-1-j]).
  - Full-width product WIDTHOUT+WIDTHIN bits; right shift truncates (no rounding); overflow wraps silently.
- Coefficient writes:
  - A write is accepted only when o_busy = 0 and i_coef_addr < NTERMS. The new value is used by samples accepted from the next cycle on.
  - A write while o_busy = 1, or with an out-of-range address, is dropped; o_coef_err pulses high the following cycle.
  - If i_coef_we and an accepted i_valid occur in the same cycle with o_busy = 0, the write succeeds and that sample uses the old coefficient.
- o_busy = OR of all stage valid bits (registered valids, no combinational path from i_valid).
- Reset mid-operation flushes all in-flight samples (no output is produced for them) and restores the default coefficients.

Decomposition:
- Shared package horner_pkg:
  - EXP_COEF constant array (16 × 16-bit, zero-padded).
  - Q-format default localparams.
  - $clog2-derived address width helper.
- One natural sub-module, horner_stage: one MAC stage (acc/x/valid registers, enable input), instantiated NTERMS-1 times in a generate loop.

Test Plan:
- Reset defaults; x = 0x0000, i_ready = 1 → o_y = 0x0200_0000 (1.0) in cycle 6; x = 0x4000 → o_y = 0x056E_E000.
- Back-to-back stream of 20 random x, i_ready = 1 → 20 outputs, in order, matching the golden model, one per cycle.
- Drop i_ready for 4 cycles mid-stream → o_ready = 0 while o_valid = 1; o_y is stable; no samples lost or duplicated.
- With the pipeline idle, write coef[0] = 0x0000, then x = 0 → o_y = 0. A write during o_busy = 1 → o_coef_err pulse, and the coefficient is unchanged.
- Write to address NTERMS (6) → o_coef_err = 1 and the coefficient bank is unchanged.
- Assert reset with 3 samples in flight → o_valid = 0 and o_y = 0 immediately; no stale outputs after release; coefficients back to defaults.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared constants for the Horner polynomial pipeline: default Q formats,
// the e^x Taylor coefficients loaded at reset, and the address-width helper.
package horner_pkg;

   localparam int DEF_WIDTHIN  = 16;
   localparam int DEF_FRAC_IN  = 14;
   localparam int DEF_WIDTHOUT = 32;
   localparam int DEF_FRAC_OUT = 25;
   localparam int DEF_NTERMS   = 6;
   localparam int MAX_NTERMS   = 16;

   typedef logic [15:0] coef16_t;

   // 1/k! in Q2.14, zero beyond the sixth term
   localparam coef16_t EXP_COEF [MAX_NTERMS] = '{
      16'h4000, 16'h4000, 16'h2000, 16'h0AAA, 16'h02AA, 16'h0088,
      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
      16'h0000, 16'h0000, 16'h0000, 16'h0000
   };

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/horner_if.sv
// Stream and coefficient-port bundle of horner_pipe; names are seen from the
// pipeline side (i_* driven by the environment, o_* driven by the pipeline).
interface horner_if
   import horner_pkg::*;
#(
   parameter int WIDTHIN  = DEF_WIDTHIN,
   parameter int WIDTHOUT = DEF_WIDTHOUT,
   parameter int NTERMS   = DEF_NTERMS
);
   localparam int AW = addr_w(NTERMS);

   logic                i_valid;
   logic                o_ready;
   logic [WIDTHIN-1:0]  i_x;
   logic                o_valid;
   logic                i_ready;
   logic [WIDTHOUT-1:0] o_y;
   logic                i_coef_we;
   logic [AW-1:0]       i_coef_addr;
   logic [WIDTHIN-1:0]  i_coef_wdata;
   logic                o_coef_err;
   logic                o_busy;

   modport master (
      output i_valid, i_x, i_ready, i_coef_we, i_coef_addr, i_coef_wdata,
      input  o_ready, o_valid, o_y, o_coef_err, o_busy
   );

   modport slave (
      input  i_valid, i_x, i_ready, i_coef_we, i_coef_addr, i_coef_wdata,
      output o_ready, o_valid, o_y, o_coef_err, o_busy
   );

endinterface

// File: rtl/horner_stage.sv
// One Horner multiply-add step: acc' = trunc((acc * x) >> FRAC_IN) + addend,
// registered together with the sample's valid, coefficient tag and x copy.
module horner_stage #(
   parameter int WIDTHIN  = 16,
   parameter int FRAC_IN  = 14,
   parameter int WIDTHOUT = 32,
   parameter bit LAST     = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_en,
   input  logic                i_vld,
   input  logic                i_tag,
   input  logic [WIDTHIN-1:0]  i_x,
   input  logic [WIDTHOUT-1:0] i_acc,
   input  logic [WIDTHOUT-1:0] i_addend,
   output logic                o_vld,
   output logic                o_tag,
   output logic [WIDTHIN-1:0]  o_x,
   output logic [WIDTHOUT-1:0] o_acc
);

   // Full-width product, then drop FRAC_IN fraction bits and any overflow.
   function automatic logic [WIDTHOUT-1:0] mul_trunc(
      input logic [WIDTHOUT-1:0] a,
      input logic [WIDTHIN-1:0]  x
   );
      return WIDTHOUT'(({{WIDTHIN{1'b0}}, a} * {{WIDTHOUT{1'b0}}, x}) >> FRAC_IN);
   endfunction

   logic                r_vld;
   logic                r_tag;
   logic [WIDTHIN-1:0]  r_x;
   logic [WIDTHOUT-1:0] r_acc;
   logic [WIDTHOUT-1:0] w_acc_nxt;

   assign w_acc_nxt = mul_trunc(i_acc, i_x) + i_addend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld <= 1'b0;
         r_tag <= 1'b0;
      end else if (i_en) begin
         r_vld <= i_vld;
         r_tag <= i_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (i_en) r_x <= i_x;
   end

   // Only the final accumulator is visible (o_y), so only it is cleared.
   if (LAST) begin : g_acc_rst
      always_ff @(posedge clk or posedge reset) begin
         if (reset)     r_acc <= '0;
         else if (i_en) r_acc <= w_acc_nxt;
      end
   end else begin : g_acc
      always_ff @(posedge clk) begin
         if (i_en) r_acc <= w_acc_nxt;
      end
   end

   assign o_vld = r_vld;
   assign o_tag = r_tag;
   assign o_x   = r_x;
   assign o_acc = r_acc;

endmodule

// File: rtl/horner_pipe.sv
// Fully pipelined polynomial evaluator (Horner's rule) with valid/ready
// backpressure and a runtime-writable coefficient bank.
module horner_pipe
   import horner_pkg::*;
#(
   parameter int WIDTHIN  = DEF_WIDTHIN,
   parameter int FRAC_IN  = DEF_FRAC_IN,
   parameter int WIDTHOUT = DEF_WIDTHOUT,
   parameter int FRAC_OUT = DEF_FRAC_OUT,
   parameter int NTERMS   = DEF_NTERMS
) (
   input  logic     clk,
   input  logic     reset,
   horner_if.slave  bus
);

   localparam int AW       = addr_w(NTERMS);
   localparam int ALIGN_SH = FRAC_OUT - FRAC_IN;

   if (FRAC_OUT < FRAC_IN) begin : g_chk_frac
      $error("horner_pipe: FRAC_OUT must be >= FRAC_IN");
   end
   if (NTERMS < 2 || NTERMS > MAX_NTERMS) begin : g_chk_terms
      $error("horner_pipe: NTERMS must be in 2..16");
   end

   function automatic logic [WIDTHOUT-1:0] align(input logic [WIDTHIN-1:0] c);
      return WIDTHOUT'(c) << ALIGN_SH;
   endfunction

   logic                w_adv;
   logic                w_busy;
   logic                w_addr_ok;
   logic                w_wr_ok;

   logic [WIDTHIN-1:0]  r_coef [NTERMS];
   logic [WIDTHIN-1:0]  w_coef_old [NTERMS];
   logic [AW-1:0]       r_prev_addr;
   logic [WIDTHIN-1:0]  r_prev_data;
   logic                r_coef_err;

   logic                r_vld_p0;
   logic                r_tag_p0;
   logic [WIDTHIN-1:0]  r_x_p0;

   logic                w_vld [NTERMS];
   logic                w_tag [NTERMS];
   logic [WIDTHIN-1:0]  w_x   [NTERMS];
   logic [WIDTHOUT-1:0] w_acc [NTERMS];

   assign w_adv     = ~w_vld[NTERMS-1] | bus.i_ready;
   assign w_addr_ok = {1'b0, bus.i_coef_addr} < (AW+1)'(NTERMS);
   assign w_wr_ok   = bus.i_coef_we & ~w_busy & w_addr_ok;

   always_comb begin
      w_busy = 1'b0;
      for (int j = 0; j < NTERMS; j++) w_busy = w_busy | w_vld[j];
   end

   // Coefficient bank; writes land only while the pipeline is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NTERMS; k++) r_coef[k] <= WIDTHIN'(EXP_COEF[k]);
         r_coef_err <= 1'b0;
      end else begin
         r_coef_err <= bus.i_coef_we & ~w_wr_ok;
         if (w_wr_ok) r_coef[bus.i_coef_addr] <= bus.i_coef_wdata;
      end
   end

   // A sample accepted in the same cycle as a write is tagged and keeps
   // seeing the overwritten value; no further write can occur while it flies.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_prev_addr <= bus.i_coef_addr;
         r_prev_data <= r_coef[bus.i_coef_addr];
      end
   end

   for (genvar k = 0; k < NTERMS; k++) begin : g_old
      assign w_coef_old[k] = (r_prev_addr == AW'(k)) ? r_prev_data : r_coef[k];
   end

   // ---- stage p0: input register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld_p0 <= 1'b0;
         r_tag_p0 <= 1'b0;
      end else if (w_adv) begin
         r_vld_p0 <= bus.i_valid;
         r_tag_p0 <= bus.i_valid & w_wr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) r_x_p0 <= bus.i_x;
   end

   assign w_vld[0] = r_vld_p0;
   assign w_tag[0] = r_tag_p0;
   assign w_x[0]   = r_x_p0;
   assign w_acc[0] = align(r_tag_p0 ? w_coef_old[NTERMS-1] : r_coef[NTERMS-1]);

   // ---- stages p1..p(NTERMS-1): MAC steps ----
   for (genvar j = 1; j < NTERMS; j++) begin : g_stage
      logic [WIDTHIN-1:0] w_coef;

      assign w_coef = w_tag[j-1] ? w_coef_old[NTERMS-1-j] : r_coef[NTERMS-1-j];

      horner_stage #(
         .WIDTHIN  (WIDTHIN),
         .FRAC_IN  (FRAC_IN),
         .WIDTHOUT (WIDTHOUT),
         .LAST     (j == NTERMS-1)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .i_en     (w_adv),
         .i_vld    (w_vld[j-1]),
         .i_tag    (w_tag[j-1]),
         .i_x      (w_x[j-1]),
         .i_acc    (w_acc[j-1]),
         .i_addend (align(w_coef)),
         .o_vld    (w_vld[j]),
         .o_tag    (w_tag[j]),
         .o_x      (w_x[j]),
         .o_acc    (w_acc[j])
      );
   end

   assign bus.o_ready    = w_adv;
   assign bus.o_valid    = w_vld[NTERMS-1];
   assign bus.o_y        = w_acc[NTERMS-1];
   assign bus.o_coef_err = r_coef_err;
   assign bus.o_busy     = w_busy;

endmodule

// File: tb/tb_horner_pipe.sv
// Directed bench for horner_pipe: defaults, streaming, backpressure,
// coefficient writes (good, busy, same-cycle, bad address) and reset flush.
module tb_horner_pipe;
   import horner_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   horner_if #(.WIDTHIN(16), .WIDTHOUT(32), .NTERMS(6)) bus ();

   horner_pipe #(
      .WIDTHIN(16), .FRAC_IN(14), .WIDTHOUT(32), .FRAC_OUT(25), .NTERMS(6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] tb_coef [6];
   logic [31:0] exp_q [$];
   logic [15:0] stim [20];

   function automatic logic [31:0] model(input logic [15:0] x);
      logic [31:0] acc;
      logic [47:0] p;
      acc = {16'h0, tb_coef[5]} << 11;
      for (int j = 4; j >= 0; j--) begin
         p   = {16'h0, acc} * {32'h0, x};
         acc = p[45:14] + ({16'h0, tb_coef[j]} << 11);
      end
      return acc;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load_defaults();
      for (int k = 0; k < 6; k++) tb_coef[k] = EXP_COEF[k];
   endtask

   // Sends one sample with i_ready high and reports when/what came out.
   task automatic run_one(input logic [15:0] x, output logic seen,
                          output logic [31:0] y, output int lat);
      bus.i_valid = 1'b1;
      bus.i_x     = x;
      bus.i_ready = 1'b1;
      next_cycle();
      bus.i_valid = 1'b0;
      seen = 1'b0;
      y    = '0;
      lat  = 0;
      for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
         @(negedge clk);
         if (bus.o_valid) begin
            seen = 1'b1;
            y    = bus.o_y;
            lat  = cyc;
         end
         next_cycle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", bus.o_valid); end
      total++;
      if (bus.o_y !== 32'h0) begin bad++; $display("FAIL reset_o_y got=%h want=0", bus.o_y); end
      total++;
      if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_o_busy got=%b want=0", bus.o_busy); end
      total++;
      if (bus.o_coef_err !== 1'b0) begin bad++; $display("FAIL reset_coef_err got=%b want=0", bus.o_coef_err); end
      total++;
      if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_o_ready got=%b want=1", bus.o_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_defaults();
      logic [15:0] xs   [2];
      logic [31:0] want [2];
      logic        seen;
      logic [31:0] y;
      int          lat;
      xs[0] = 16'h0000; want[0] = 32'h0200_0000;
      xs[1] = 16'h4000; want[1] = 32'h056E_E000;
      for (int v = 0; v < 2; v++) begin
         run_one(xs[v], seen, y, lat);
         total++;
         if (!seen) begin
            bad++; $display("FAIL defaults_timeout x=%h got=none want=%h", xs[v], want[v]);
         end else begin
            total++;
            if (lat != 6) begin bad++; $display("FAIL defaults_latency got=%0d want=6", lat); end
            if (y !== want[v]) begin bad++; $display("FAIL defaults_y x=%h got=%h want=%h", xs[v], y, want[v]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int idx = 0, outs = 0, first = -1, last = -1;
      logic [31:0] e;
      exp_q.delete();
      for (int cyc = 0; cyc < 60 && outs < 20; cyc++) begin
         bus.i_ready = 1'b1;
         bus.i_valid = (idx < 20);
         if (idx < 20) bus.i_x = stim[idx];
         @(negedge clk);
         if (bus.o_valid && bus.i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_extra got=%h want=none", bus.o_y);
            end else begin
               e = exp_q.pop_front();
               if (bus.o_y !== e) begin bad++; $display("FAIL b2b_y n=%0d got=%h want=%h", outs, bus.o_y, e); end
            end
            if (first < 0) first = cyc;
            last = cyc;
            outs++;
         end
         if (bus.i_valid && bus.o_ready) begin
            exp_q.push_back(model(bus.i_x));
            idx++;
         end
         next_cycle();
      end
      bus.i_valid = 1'b0;
      total++;
      if (outs != 20) begin bad++; $display("FAIL b2b_count got=%0d want=20", outs); end
      total++;
      if (last - first != 19) begin bad++; $display("FAIL b2b_rate got=%0d want=19", last - first); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_stall();
      int idx = 0, outs = 0, stalls = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_y = '0;
      logic [31:0] e;
      exp_q.delete();
      for (int cyc = 0; cyc < 60 && outs < 10; cyc++) begin
         bus.i_ready = !(cyc >= 8 && cyc < 12);
         bus.i_valid = (idx < 10);
         if (idx < 10) bus.i_x = stim[idx];
         @(negedge clk);
         if (prev_stall) begin
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_y !== prev_y) begin
               bad++; $display("FAIL stall_hold got=%b/%h want=1/%h", bus.o_valid, bus.o_y, prev_y);
            end
         end
         if (bus.o_valid && !bus.i_ready) begin
            stalls++;
            total++;
            if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL stall_o_ready got=%b want=0", bus.o_ready); end
         end
         if (bus.o_valid && bus.i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL stall_extra got=%h want=none", bus.o_y);
            end else begin
               e = exp_q.pop_front();
               if (bus.o_y !== e) begin bad++; $display("FAIL stall_y n=%0d got=%h want=%h", outs, bus.o_y, e); end
            end
            outs++;
         end
         if (bus.i_valid && bus.o_ready) begin
            exp_q.push_back(model(bus.i_x));
            idx++;
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_y     = bus.o_y;
         next_cycle();
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      total++;
      if (outs != 10) begin bad++; $display("FAIL stall_count got=%0d want=10", outs); end
      total++;
      if (stalls != 4) begin bad++; $display("FAIL stall_cycles got=%0d want=4", stalls); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL stall_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_coef_write();
      logic        seen;
      logic [31:0] y;
      int          lat;
      bool_wait : for (int i = 0; i < 20 && bus.o_busy; i++) next_cycle();
      total++;
      if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL coef_idle_timeout got=%b want=0", bus.o_busy); end
      // good write: c0 = 0
      bus.i_coef_we = 1'b1; bus.i_coef_addr = 3'd0; bus.i_coef_wdata = 16'h0000;
      next_cycle();
      bus.i_coef_we = 1'b0;
      tb_coef[0] = 16'h0000;
      @(negedge clk);
      total++;
      if (bus.o_coef_err !== 1'b0) begin bad++; $display("FAIL coef_ok_err got=%b want=0", bus.o_coef_err); end
      next_cycle();
      run_one(16'h0000, seen, y, lat);
      total++;
      if (!seen || y !== 32'h0) begin bad++; $display("FAIL coef_c0_zero got=%h want=00000000", y); end
      // write while busy: c1 must stay 0x4000
      bus.i_valid = 1'b1; bus.i_x = 16'h4000; bus.i_ready = 1'b1;
      next_cycle();
      bus.i_valid = 1'b0;
      bus.i_coef_we = 1'b1; bus.i_coef_addr = 3'd1; bus.i_coef_wdata = 16'h1234;
      next_cycle();
      bus.i_coef_we = 1'b0;
      @(negedge clk);
      total++;
      if (bus.o_coef_err !== 1'b1) begin bad++; $display("FAIL coef_busy_err got=%b want=1", bus.o_coef_err); end
      next_cycle();
      @(negedge clk);
      total++;
      if (bus.o_coef_err !== 1'b0) begin bad++; $display("FAIL coef_err_pulse got=%b want=0", bus.o_coef_err); end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.o_valid) begin seen = 1'b1; y = bus.o_y; end
         next_cycle();
         if (!seen) @(negedge clk);
      end
      total++;
      if (!seen || y !== 32'h036E_E000) begin bad++; $display("FAIL coef_busy_inflight got=%h want=036ee000", y); end
      run_one(16'h4000, seen, y, lat);
      total++;
      if (!seen || y !== 32'h036E_E000) begin bad++; $display("FAIL coef_busy_unchanged got=%h want=036ee000", y); end
   endtask

   task automatic test_same_cycle_write();
      logic [31:0] got [2];
      int n = 0;
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b1; bus.i_x = 16'h4000;
      bus.i_coef_we = 1'b1; bus.i_coef_addr = 3'd5; bus.i_coef_wdata = 16'h0000;
      next_cycle();
      bus.i_coef_we = 1'b0;
      tb_coef[5] = 16'h0000;
      @(negedge clk);
      total++;
      if (bus.o_coef_err !== 1'b0) begin bad++; $display("FAIL same_err got=%b want=0", bus.o_coef_err); end
      next_cycle();
      bus.i_valid = 1'b0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clk);
         if (bus.o_valid) begin got[n] = bus.o_y; n++; end
         next_cycle();
      end
      total++;
      if (n != 2) begin
         bad++; $display("FAIL same_count got=%0d want=2", n);
      end else begin
         total++;
         if (got[0] !== 32'h036E_E000) begin bad++; $display("FAIL same_old_coef got=%h want=036ee000", got[0]); end
         if (got[1] !== 32'h036A_A000) begin bad++; $display("FAIL same_new_coef got=%h want=036aa000", got[1]); end
      end
   endtask

   task automatic test_bad_addr();
      logic        seen;
      logic [31:0] y;
      int          lat;
      bus.i_coef_we = 1'b1; bus.i_coef_addr = 3'd6; bus.i_coef_wdata = 16'h7777;
      next_cycle();
      bus.i_coef_we = 1'b0;
      @(negedge clk);
      total++;
      if (bus.o_coef_err !== 1'b1) begin bad++; $display("FAIL badaddr_err got=%b want=1", bus.o_coef_err); end
      next_cycle();
      run_one(16'h4000, seen, y, lat);
      total++;
      if (!seen || y !== 32'h036A_A000) begin bad++; $display("FAIL badaddr_bank got=%h want=036aa000", y); end
      total++;
      if (model(16'h4000) !== y) begin bad++; $display("FAIL badaddr_model got=%h want=%h", y, model(16'h4000)); end
   endtask

   task automatic test_reset_flush();
      logic        seen;
      logic [31:0] y;
      int          lat;
      int          stale = 0;
      bus.i_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.i_valid = 1'b1; bus.i_x = stim[i];
         next_cycle();
      end
      bus.i_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.o_valid) seen = 1'b1;
         else next_cycle();
      end
      total++;
      if (!seen) begin bad++; $display("FAIL flush_setup got=none want=o_valid"); end
      reset = 1'b1;
      #1;
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_y !== 32'h0) begin
         bad++; $display("FAIL flush_immediate got=%b/%h want=0/00000000", bus.o_valid, bus.o_y);
      end
      total++;
      if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.o_busy); end
      @(posedge clk);
      #1 reset = 1'b0;
      load_defaults();
      bus.i_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.o_valid) stale++;
         next_cycle();
      end
      total++;
      if (stale != 0) begin bad++; $display("FAIL flush_stale got=%0d want=0", stale); end
      run_one(16'h4000, seen, y, lat);
      total++;
      if (!seen || y !== 32'h056E_E000) begin bad++; $display("FAIL flush_defaults got=%h want=056ee000", y); end
   endtask

   initial begin
      reset            = 1'b1;
      bus.i_valid      = 1'b0;
      bus.i_x          = '0;
      bus.i_ready      = 1'b1;
      bus.i_coef_we    = 1'b0;
      bus.i_coef_addr  = '0;
      bus.i_coef_wdata = '0;
      stim = '{16'h0000, 16'h4000, 16'hFFFF, 16'h8000, 16'h2000, 16'h1234, 16'hABCD,
               16'h0001, 16'h7FFF, 16'hC000, 16'h3C3C, 16'h5A5A, 16'h0F0F, 16'hF0F0,
               16'h6000, 16'hA000, 16'h0800, 16'hE000, 16'h9999, 16'h4001};
      load_defaults();

      test_reset();
      test_defaults();
      test_back_to_back();
      test_stall();
      test_coef_write();
      test_same_cycle_write();
      test_bad_addr();
      test_reset_flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
